adder_share_ctrl: RTL

- Byte-serial multi-precision addition controller.
- Shares one external 8-bit ripple-carry adder (sum plus carry-out) between two requesters.
- Each request is a NUM_BYTES-wide addition. The block arbitrates round-robin, latches the winner's operands, and feeds the adder one byte per cycle, LSB first, chaining carry through a register.
- It returns the full-width sum and final carry to the winner.

---
 rtl/adder_share_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/adder_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : adder_share_ctrl
//  Description : Byte-serial multi-precision addition controller. Two
//                requesters share one external 8-bit ripple-carry adder. A
//                round-robin arbiter picks the owner. The winner's operands are
//                latched and fed LSB-first, one byte per cycle, with the carry
//                chained through a register. The full-width sum and final
//                carry go back to the owner with a one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_share_ctrl #(
    parameter int NUM_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req,
    input  logic [8*NUM_BYTES-1:0] op_a0,
    input  logic [8*NUM_BYTES-1:0] op_b0,
    input  logic                   cin0,
    input  logic [8*NUM_BYTES-1:0] op_a1,
    input  logic [8*NUM_BYTES-1:0] op_b1,
    input  logic                   cin1,
    output logic [1:0]             grant,
    output logic [1:0]             done,
    output logic [8*NUM_BYTES-1:0] result,
    output logic                   carry_out,
    output logic                   busy,
    output logic [7:0]             add_a,
    output logic [7:0]             add_b,
    output logic                   add_cin,
    input  logic [7:0]             add_sum,
    input  logic                   add_cout
);

    localparam int c_W     = 8 * NUM_BYTES;
    localparam int c_IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_BYTES - 1);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_ADD  = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    // Reject operand widths outside the supported 1..16 byte range at elaboration.
    if (NUM_BYTES < 1 || NUM_BYTES > 16) begin : g_bad_num_bytes
        $error("adder_share_ctrl: NUM_BYTES must be in 1..16");
    end

    logic [1:0]         r_state;
    logic               r_rr_ptr;
    logic [1:0]         r_grant;
    logic [1:0]         r_done;
    logic [c_W-1:0]     r_result;
    logic               r_carry_out;
    logic               r_busy;
    logic [c_W-1:0]     r_sh_a;
    logic [c_W-1:0]     r_sh_b;
    logic               r_carry;
    logic [c_IDX_W-1:0] r_idx;

    logic               w_has_winner;
    logic               w_win;
    logic [c_W-1:0]     w_op_a;
    logic [c_W-1:0]     w_op_b;
    logic               w_cin;
    logic               w_in_add;

    // Round-robin winner selection: a lone request wins outright, a tie goes to rr_ptr.
    always_comb begin
        w_has_winner = |req;
        w_win        = (req == 2'b11) ? r_rr_ptr : req[1];
        w_op_a       = w_win ? op_a1 : op_a0;
        w_op_b       = w_win ? op_b1 : op_b0;
        w_cin        = w_win ? cin1  : cin0;
    end

    // Adder inputs carry the current low bytes only while adding, zero otherwise.
    assign w_in_add = (r_state == c_S_ADD);
    assign add_a    = w_in_add ? r_sh_a[7:0] : 8'd0;
    assign add_b    = w_in_add ? r_sh_b[7:0] : 8'd0;
    assign add_cin  = w_in_add ? r_carry     : 1'b0;

    assign grant     = r_grant;
    assign done      = r_done;
    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign busy      = r_busy;

    // Controller FSM: arbitrate in IDLE, stream bytes through the adder in ADD,
    // pulse done for one cycle in DONE and hand priority to the other requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_S_IDLE;
            r_rr_ptr    <= 1'b0;
            r_grant     <= 2'b00;
            r_done      <= 2'b00;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_busy      <= 1'b0;
            r_sh_a      <= '0;
            r_sh_b      <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_has_winner) begin
                        r_sh_a  <= w_op_a;
                        r_sh_b  <= w_op_b;
                        r_carry <= w_cin;
                        r_idx   <= '0;
                        r_grant <= w_win ? 2'b10 : 2'b01;
                        r_busy  <= 1'b1;
                        r_state <= c_S_ADD;
                    end
                end
                c_S_ADD: begin
                    r_result[{r_idx, 3'b000} +: 8] <= add_sum;
                    r_carry <= add_cout;
                    r_sh_a  <= r_sh_a >> 8;
                    r_sh_b  <= r_sh_b >> 8;
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == c_LAST_IDX) begin
                        r_carry_out <= add_cout;
                        r_done      <= r_grant;
                        r_state     <= c_S_DONE;
                    end
                end
                c_S_DONE: begin
                    // The requester just served drops to lowest priority.
                    r_rr_ptr <= ~r_grant[1];
                    r_grant  <= 2'b00;
                    r_done   <= 2'b00;
                    r_busy   <= 1'b0;
                    r_state  <= c_S_IDLE;
                end
                default: begin
                    r_grant <= 2'b00;
                    r_done  <= 2'b00;
                    r_busy  <= 1'b0;
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
